// File: rtl/rf_sched_pkg.sv
// Shared state encodings for the RF transceiver scheduler.
// The SELF_CHECK state is only reachable when RF_SCHED_SELF_CHECK_EN is defined.
package rf_sched_pkg;

  localparam int unsigned MODULE_IDLE_STATE     = 3;
  localparam int unsigned MODULE_WTRANS_STATE   = 2;
  localparam int unsigned MODULE_WRECEIVE_STATE = 1;
  localparam int unsigned MODULE_PROGRAM_STATE  = 0;

  localparam logic [3:0] ONEHOT_IDLE      = 4'b1000;
  localparam logic [3:0] ONEHOT_WTRANS    = 4'b0100;
  localparam logic [3:0] ONEHOT_WRECEIVE  = 4'b0010;
  localparam logic [3:0] ONEHOT_PROGRAM   = 4'b0001;
  localparam logic [3:0] ONEHOT_SELFCHECK = 4'b0000;

  typedef enum logic [2:0] {
    StIdle,
    StWtrans,
    StWreceive,
    StProgram,
    StSelfCheck
  } sched_state_e;

  function automatic logic [3:0] state_onehot(sched_state_e st);
    logic [3:0] oh;
    oh = ONEHOT_SELFCHECK;
    unique case (st)
      StIdle:     oh = ONEHOT_IDLE;
      StWtrans:   oh = ONEHOT_WTRANS;
      StWreceive: oh = ONEHOT_WRECEIVE;
      StProgram:  oh = ONEHOT_PROGRAM;
      default:    oh = ONEHOT_SELFCHECK;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/rf_state_scheduler_if.sv
// Datapath-facing signal bundle of the scheduler; slave = scheduler, master = datapath side.
interface rf_state_scheduler_if #(
  parameter int unsigned CNT_WIDTH = 7
);
  logic                 M0_sync;
  logic                 M1_sync;
  logic                 mcu_rx_flag;
  logic [CNT_WIDTH-1:0] buf_count;
  logic                 node_tx_complete;
  logic                 node_rx_flag;
  logic                 mcu_tx_idle;
  logic                 prog_idle;
  logic [3:0]           state_module;
  logic                 trans_start;
  logic                 AUX_state_ctrl;

  modport master (
    output M0_sync, M1_sync, mcu_rx_flag, buf_count, node_tx_complete, node_rx_flag,
    output mcu_tx_idle, prog_idle,
    input  state_module, trans_start, AUX_state_ctrl
  );

  modport slave (
    input  M0_sync, M1_sync, mcu_rx_flag, buf_count, node_tx_complete, node_rx_flag,
    input  mcu_tx_idle, prog_idle,
    output state_module, trans_start, AUX_state_ctrl
  );
endinterface

// File: rtl/rf_timeout_counter.sv
// Saturating up-counter counting 0..END-1; terminal is high while parked at END-1.
module rf_timeout_counter #(
  parameter int unsigned END   = 5000,
  parameter int unsigned WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);
  localparam logic [WIDTH-1:0] TermVal = WIDTH'(END - 1);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != TermVal)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == TermVal);
endmodule

// File: rtl/rf_state_scheduler.sv
// Central RF transceiver scheduler: owns the one-hot state_module vector and AUX state.
// Define RF_SCHED_SELF_CHECK_EN to add a post-reset SELF_CHECK phase.
module rf_state_scheduler #(
  parameter int unsigned CNT_WIDTH                   = 7,
  parameter int unsigned START_WIRELESS_TRANS_VALUE  = 58,
  parameter int unsigned END_WAITING_SEND_WLESS_DATA = 5000,
  parameter int unsigned END_COUNTER_RX_PACKET       = 5000,
  parameter int unsigned END_SELF_CHECKING           = 5000,
  parameter int unsigned TIMER_WIDTH                 = 16
) (
  input logic           internal_clk,
  input logic           rst,
  rf_state_scheduler_if.slave bus
);
  import rf_sched_pkg::*;

  localparam logic [CNT_WIDTH-1:0] StartLevel = CNT_WIDTH'(START_WIRELESS_TRANS_VALUE);

`ifdef RF_SCHED_SELF_CHECK_EN
  localparam sched_state_e ResetState = StSelfCheck;
`else
  localparam sched_state_e ResetState = StIdle;
`endif

  sched_state_e state_q, state_d;
  logic [3:0]   state_module_q, state_module_d;
  logic         trans_start_q, trans_start_d;
  logic         aux_q, aux_d;

  logic mode3, buf_empty, idle_term, rx_term;

  assign mode3     = bus.M1_sync & bus.M0_sync;
  assign buf_empty = (bus.buf_count == '0);

  rf_timeout_counter #(
    .END   (END_WAITING_SEND_WLESS_DATA),
    .WIDTH (TIMER_WIDTH)
  ) u_idle_timer (
    .clk      (internal_clk),
    .rst      (rst),
    .clear    (bus.mcu_rx_flag | buf_empty | (state_q != StIdle)),
    .enable   (state_q == StIdle),
    .terminal (idle_term)
  );

  // Holding clear outside WRECEIVE makes every entry start from zero.
  rf_timeout_counter #(
    .END   (END_COUNTER_RX_PACKET),
    .WIDTH (TIMER_WIDTH)
  ) u_silence_timer (
    .clk      (internal_clk),
    .rst      (rst),
    .clear    (bus.node_rx_flag | (state_q != StWreceive)),
    .enable   (state_q == StWreceive),
    .terminal (rx_term)
  );

`ifdef RF_SCHED_SELF_CHECK_EN
  logic self_term;

  rf_timeout_counter #(
    .END   (END_SELF_CHECKING),
    .WIDTH (TIMER_WIDTH)
  ) u_self_check_timer (
    .clk      (internal_clk),
    .rst      (rst),
    .clear    (state_q != StSelfCheck),
    .enable   (state_q == StSelfCheck),
    .terminal (self_term)
  );
`else
  logic unused_self_check_end;
  assign unused_self_check_end = (END_SELF_CHECKING != 0);
`endif

  always_ff @(posedge internal_clk) begin
    if (rst) begin
      state_q        <= ResetState;
      state_module_q <= state_onehot(ResetState);
      trans_start_q  <= 1'b0;
      aux_q          <= (ResetState == StIdle);
    end else begin
      state_q        <= state_d;
      state_module_q <= state_module_d;
      trans_start_q  <= trans_start_d;
      aux_q          <= aux_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (mode3) begin
          state_d = StProgram;
        end else if (bus.node_rx_flag) begin
          state_d = StWreceive;
        end else if (bus.buf_count >= StartLevel) begin
          state_d = StWtrans;
        end else if (!buf_empty && idle_term && !bus.mcu_rx_flag) begin
          // A byte arriving on the terminal cycle restarts the wait instead.
          state_d = StWtrans;
        end
      end
      StWtrans: begin
        if (bus.node_tx_complete && buf_empty) state_d = StIdle;
      end
      StWreceive: begin
        if (rx_term && bus.mcu_tx_idle) state_d = StIdle;
      end
      StProgram: begin
        if (!mode3 && bus.prog_idle) state_d = StIdle;
      end
`ifdef RF_SCHED_SELF_CHECK_EN
      StSelfCheck: begin
        if (self_term) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so the registers line up with state_q.
  always_comb begin
    state_module_d = state_onehot(state_d);
    trans_start_d  = (state_d == StWtrans) && (state_q != StWtrans);
    aux_d          = (state_d == StIdle);
  end

  assign bus.state_module   = state_module_q;
  assign bus.trans_start    = trans_start_q;
  assign bus.AUX_state_ctrl = aux_q;
endmodule

// File: tb/tb_rf_state_scheduler.sv
// Directed self-checking bench for rf_state_scheduler (default parameters).
module tb_rf_state_scheduler;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rf_state_scheduler_if #(.CNT_WIDTH(7)) bus ();

  rf_state_scheduler dut (
    .internal_clk (clk),
    .rst          (rst),
    .bus          (bus)
  );

`ifdef RF_SCHED_SELF_CHECK_EN
  localparam logic [3:0] RstState = 4'b0000;
  localparam logic       RstAux   = 1'b0;
`else
  localparam logic [3:0] RstState = 4'b1000;
  localparam logic       RstAux   = 1'b1;
`endif

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] st, input logic ts,
                          input logic aux);
    chk({tag, ".state"}, 32'(bus.state_module), 32'(st));
    chk({tag, ".trans_start"}, 32'(bus.trans_start), 32'(ts));
    chk({tag, ".aux"}, 32'(bus.AUX_state_ctrl), 32'(aux));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic mcu_byte(input logic [6:0] cnt);
    bus.mcu_rx_flag = 1'b1;
    bus.buf_count   = cnt;
    tick();
    bus.mcu_rx_flag = 1'b0;
  endtask

  task automatic node_byte();
    bus.node_rx_flag = 1'b1;
    tick();
    bus.node_rx_flag = 1'b0;
  endtask

  initial begin
    rst                  = 1'b1;
    bus.M0_sync          = 1'b0;
    bus.M1_sync          = 1'b0;
    bus.mcu_rx_flag      = 1'b0;
    bus.buf_count        = '0;
    bus.node_tx_complete = 1'b0;
    bus.node_rx_flag     = 1'b0;
    bus.mcu_tx_idle      = 1'b1;
    bus.prog_idle        = 1'b1;
    ticks(2);
    chk_outs("reset", RstState, 1'b0, RstAux);
    rst = 1'b0;

`ifdef RF_SCHED_SELF_CHECK_EN
    ticks(4999);
    chk_outs("selfcheck_hold", 4'b0000, 1'b0, 1'b0);
    tick();
    chk_outs("selfcheck_done", 4'b1000, 1'b0, 1'b1);
`endif

    // Threshold send
    for (int i = 1; i <= 57; i++) mcu_byte(7'(i));
    chk_outs("thr_below", 4'b1000, 1'b0, 1'b1);
    mcu_byte(7'd58);
    chk_outs("thr_enter", 4'b0100, 1'b1, 1'b0);
    bus.M0_sync      = 1'b1;
    bus.M1_sync      = 1'b1;
    bus.node_rx_flag = 1'b1;
    tick();
    chk_outs("thr_ignore", 4'b0100, 1'b0, 1'b0);
    bus.M0_sync      = 1'b0;
    bus.M1_sync      = 1'b0;
    bus.node_rx_flag = 1'b0;
    bus.buf_count        = '0;
    bus.node_tx_complete = 1'b1;
    tick();
    chk_outs("thr_exit", 4'b1000, 1'b0, 1'b1);

    // Timeout send of a partial buffer
    mcu_byte(7'd1);
    mcu_byte(7'd2);
    mcu_byte(7'd3);
    ticks(4999);
    chk_outs("to_wait", 4'b1000, 1'b0, 1'b1);
    tick();
    chk_outs("to_enter", 4'b0100, 1'b1, 1'b0);
    bus.buf_count = '0;
    tick();
    chk_outs("to_exit", 4'b1000, 1'b0, 1'b1);

    // A byte on the terminal cycle restarts the wait
    mcu_byte(7'd1);
    ticks(4999);
    chk_outs("rs_term", 4'b1000, 1'b0, 1'b1);
    mcu_byte(7'd2);
    chk_outs("rs_clear_wins", 4'b1000, 1'b0, 1'b1);
    ticks(4999);
    chk_outs("rs_wait", 4'b1000, 1'b0, 1'b1);
    tick();
    chk_outs("rs_enter", 4'b0100, 1'b1, 1'b0);
    bus.buf_count = '0;
    tick();
    chk_outs("rs_exit", 4'b1000, 1'b0, 1'b1);

    // Receive with MCU TX already idle
    node_byte();
    chk_outs("rx_enter", 4'b0010, 1'b0, 1'b0);
    ticks(4999);
    chk_outs("rx_silence", 4'b0010, 1'b0, 1'b0);
    tick();
    chk_outs("rx_exit", 4'b1000, 1'b0, 1'b1);

    // Periodic node bytes, then MCU TX still busy past the timeout
    node_byte();
    for (int i = 0; i < 10; i++) begin
      ticks(99);
      node_byte();
      chk("rx_burst.state", 32'(bus.state_module), 32'h2);
    end
    bus.mcu_tx_idle = 1'b0;
    ticks(5100);
    chk_outs("rx_busy_hold", 4'b0010, 1'b0, 1'b0);
    bus.mcu_tx_idle = 1'b1;
    tick();
    chk_outs("rx_busy_exit", 4'b1000, 1'b0, 1'b1);

    // Priority: mode 3 beats node byte beats threshold
    bus.M0_sync      = 1'b1;
    bus.M1_sync      = 1'b1;
    bus.node_rx_flag = 1'b1;
    bus.buf_count    = 7'd60;
    tick();
    chk_outs("prio_program", 4'b0001, 1'b0, 1'b0);
    bus.node_rx_flag = 1'b0;
    bus.M0_sync      = 1'b0;
    bus.prog_idle    = 1'b0;
    ticks(3);
    chk_outs("prog_held", 4'b0001, 1'b0, 1'b0);
    bus.buf_count = '0;
    bus.prog_idle = 1'b1;
    tick();
    chk_outs("prog_exit", 4'b1000, 1'b0, 1'b1);
    bus.M1_sync = 1'b0;

    // Reset in the middle of a transmission
    bus.buf_count = 7'd58;
    tick();
    chk_outs("mid_enter", 4'b0100, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    chk_outs("mid_reset", RstState, 1'b0, RstAux);
    rst           = 1'b0;
    bus.buf_count = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
